// File: rtl/rv32i_trace_pkg.sv
// Shared types and constants for the rv32i retirement-trace collector.
// Record layout, flag bit positions and class-filter masks live here.
package rv32i_trace_pkg;

    localparam int REC_SEQ_W = 32;
    localparam int REC_W     = 233;

    localparam int FLAG_REG_WRITE = 0;
    localparam int FLAG_MEM_WRITE = 1;
    localparam int FLAG_MEM_READ  = 2;
    localparam int FLAG_BRANCH    = 3;
    localparam int FLAG_JAL       = 4;
    localparam int FLAG_JALR      = 5;

    localparam logic [2:0] FILT_REG = 3'b001;
    localparam logic [2:0] FILT_MEM = 3'b010;
    localparam logic [2:0] FILT_CF  = 3'b100;

    // The reserved MSB pad keeps the record at the full width consumers expect.
    typedef struct packed {
        logic [29:0]          rsvd;
        logic [REC_SEQ_W-1:0] seq;
        logic [31:0]          pc;
        logic [31:0]          instruction;
        logic [4:0]           rd_addr;
        logic [31:0]          wb_data;
        logic [31:0]          mem_addr;
        logic [31:0]          mem_wdata;
        logic [5:0]           flags;
    } trace_rec_t;

endpackage

// File: rtl/rv32i_trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy output.
// Full/empty come from the level counter; the pointers simply wrap.
module rv32i_trace_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   clear,
    input  logic                   push,
    input  T                       wdata,
    input  logic                   pop,
    output T                       rdata,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign valid   = (level != '0);
    assign do_pop  = pop & valid;
    assign do_push = push & ((level != FULL) | do_pop);
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + (AW+1)'(1);
            else if (!do_push && do_pop) level <= level - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/rv32i_trace_capture.sv
// Retirement-trace collector: qualifies, stamps and filters retiring
// instructions, buffers them in an FWFT FIFO and counts overflow drops.
module rv32i_trace_capture
    import rv32i_trace_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int HIGH_WATER = 12,
    parameter int SEQ_W      = 32,
    parameter int OVF_W      = 16
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   in_valid,
    input  logic [31:0]            pc_out,
    input  logic [31:0]            instruction,
    input  logic [4:0]             rd_addr,
    input  logic [31:0]            wb_data,
    input  logic                   reg_write,
    input  logic                   mem_write,
    input  logic                   mem_read,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_wdata,
    input  logic                   branch_taken,
    input  logic                   jal,
    input  logic                   jalr,
    input  logic                   trace_en,
    input  logic [2:0]             filter_mask,
    input  logic                   clear,
    output logic                   tr_valid,
    input  logic                   tr_ready,
    output trace_rec_t             tr_rec,
    output logic [$clog2(DEPTH):0] level,
    output logic [OVF_W-1:0]       ovf_cnt,
    output logic                   halt_req
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] HW   = LW'(HIGH_WATER);

    logic [SEQ_W-1:0] seq_q;
    logic [2:0]       rec_class;
    logic             cap;
    logic             pop;
    logic             push;
    logic             ovf;
    logic [LW-1:0]    level_next;
    trace_rec_t       rec;

    always_comb begin
        rec_class = {branch_taken | jal | jalr, mem_read | mem_write, reg_write};
        cap  = in_valid & trace_en & ((filter_mask == 3'b000) | (|(filter_mask & rec_class)));
        pop  = tr_valid & tr_ready;
        push = cap & ((level != FULL) | pop);
        ovf  = cap & (level == FULL) & ~pop;

        rec             = '0;
        rec.seq         = REC_SEQ_W'(seq_q);
        rec.pc          = pc_out;
        rec.instruction = instruction;
        rec.rd_addr     = reg_write ? rd_addr : 5'd0;
        rec.wb_data     = wb_data;
        rec.mem_addr    = mem_addr;
        rec.mem_wdata   = mem_wdata;
        rec.flags       = {jalr, jal, branch_taken, mem_read, mem_write, reg_write};

        level_next = level;
        if (push && !pop)      level_next = level + LW'(1);
        else if (!push && pop) level_next = level - LW'(1);
    end

    // Sequence advances on every retirement, including filtered, dropped and cleared ones.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            seq_q <= '0;
        end else if (in_valid) begin
            seq_q <= seq_q + SEQ_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n || clear) begin
            ovf_cnt  <= '0;
            halt_req <= 1'b0;
        end else begin
            if (ovf && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_W'(1);
            halt_req <= (level_next >= HW);
        end
    end

    rv32i_trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_rec_t)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .clear  (clear),
        .push   (push),
        .wdata  (rec),
        .pop    (pop),
        .rdata  (tr_rec),
        .valid  (tr_valid),
        .level  (level)
    );

endmodule

// File: tb/tb_rv32i_trace_capture.sv
// Self-checking bench for rv32i_trace_capture: directed scenarios followed by
// randomized retirements, all compared against a queue-based reference model.
module tb_rv32i_trace_capture;
    import rv32i_trace_pkg::*;

    localparam int DEPTH      = 16;
    localparam int HIGH_WATER = 12;
    localparam int OVF_W      = 16;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        in_valid;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic [4:0]  rd_addr;
    logic [31:0] wb_data;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        branch_taken;
    logic        jal;
    logic        jalr;
    logic        trace_en;
    logic [2:0]  filter_mask;
    logic        clear;
    logic        tr_valid;
    logic        tr_ready;
    trace_rec_t  tr_rec;
    logic [4:0]  level;
    logic [OVF_W-1:0] ovf_cnt;
    logic        halt_req;

    int checks = 0;
    int errors = 0;

    logic [232:0]     exp_q[$];
    logic [31:0]      m_seq;
    logic [OVF_W-1:0] m_ovf;
    logic             m_halt;

    always #5 clk = ~clk;

    rv32i_trace_capture #(
        .DEPTH(DEPTH), .HIGH_WATER(HIGH_WATER), .SEQ_W(32), .OVF_W(OVF_W)
    ) dut (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .pc_out(pc_out),
        .instruction(instruction), .rd_addr(rd_addr), .wb_data(wb_data),
        .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .branch_taken(branch_taken),
        .jal(jal), .jalr(jalr), .trace_en(trace_en), .filter_mask(filter_mask),
        .clear(clear), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_rec(tr_rec),
        .level(level), .ovf_cnt(ovf_cnt), .halt_req(halt_req)
    );

    task automatic checkOutput(input string tag, input logic [232:0] got, input logic [232:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rd,
                                 input logic [31:0] wb, input logic [5:0] fl,
                                 input logic [31:0] ma, input logic [31:0] mwd);
        in_valid     = 1'b1;
        pc_out       = pc;
        instruction  = ins;
        rd_addr      = rd;
        wb_data      = wb;
        mem_addr     = ma;
        mem_wdata    = mwd;
        {jalr, jal, branch_taken, mem_read, mem_write, reg_write} = fl;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        {jalr, jal, branch_taken, mem_read, mem_write, reg_write} = 6'b0;
    endtask

    // Reference behaviour for one clock edge, from the current inputs and model state.
    task automatic modelStep();
        logic [2:0]   cls;
        logic         cap;
        logic         popm;
        logic [232:0] rec;
        if (!arst_n) begin
            exp_q.delete();
            m_seq = 0;
            m_ovf = 0;
            m_halt = 1'b0;
            return;
        end
        cls  = {branch_taken | jal | jalr, mem_read | mem_write, reg_write};
        cap  = in_valid && trace_en && (filter_mask == 0 || (filter_mask & cls) != 0);
        popm = (exp_q.size() > 0) && tr_ready;
        rec  = {30'b0, m_seq, pc_out, instruction, reg_write ? rd_addr : 5'd0, wb_data,
                mem_addr, mem_wdata, jalr, jal, branch_taken, mem_read, mem_write, reg_write};
        if (clear) begin
            exp_q.delete();
            m_ovf = 0;
        end else begin
            if (popm) void'(exp_q.pop_front());
            if (cap) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(rec);
                else if (m_ovf != {OVF_W{1'b1}}) m_ovf = m_ovf + 1'b1;
            end
        end
        if (in_valid) m_seq = m_seq + 1;
        m_halt = (exp_q.size() >= HIGH_WATER) && !clear;
    endtask

    task automatic checkAll();
        checkOutput("tr_valid", tr_valid, exp_q.size() != 0);
        checkOutput("level", level, exp_q.size());
        checkOutput("ovf_cnt", ovf_cnt, m_ovf);
        checkOutput("halt_req", halt_req, m_halt);
        checkOutput("tr_rec", tr_rec, (exp_q.size() != 0) ? exp_q[0] : 233'd0);
    endtask

    task automatic step();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    task automatic doReset();
        arst_n = 1'b0;
        idle();
        step();
        step();
        arst_n = 1'b1;
    endtask

    initial begin
        arst_n = 1'b0; clear = 1'b0; trace_en = 1'b1; filter_mask = 3'b000; tr_ready = 1'b1;
        pc_out = 0; instruction = 0; rd_addr = 0; wb_data = 0; mem_addr = 0; mem_wdata = 0;
        idle();

        doReset();
        checkOutput("reset_level", level, 0);
        checkOutput("reset_valid", tr_valid, 0);

        // Single ADDI with an always-ready consumer.
        applyStimulus(32'h100, 32'h01000293, 5'd5, 32'h10, 6'b000001, 32'h0, 32'h0);
        step();
        idle();
        checkOutput("addi_pc", tr_rec.pc, 32'h100);
        checkOutput("addi_rd", tr_rec.rd_addr, 5);
        checkOutput("addi_flags", tr_rec.flags, 6'b000001);
        checkOutput("addi_seq", tr_rec.seq, 0);
        step();
        checkOutput("addi_drained", level, 0);

        // Memory-only filter: ADD, LW, JAL -> only the LW survives.
        doReset();
        filter_mask = FILT_MEM; tr_ready = 1'b0;
        applyStimulus(32'h200, 32'h002081b3, 5'd3, 32'h7, 6'b000001, 32'h0, 32'h0); step();
        applyStimulus(32'h204, 32'h0000a203, 5'd4, 32'h55, 6'b000101, 32'h1000, 32'h0); step();
        applyStimulus(32'h208, 32'h008000ef, 5'd1, 32'h20c, 6'b010001, 32'h0, 32'h0); step();
        idle(); step();
        checkOutput("filt_level", level, 1);
        checkOutput("filt_seq", tr_rec.seq, 1);
        checkOutput("filt_flags", tr_rec.flags, 6'b000101);

        // Fill past capacity with a stalled consumer.
        doReset();
        filter_mask = 3'b000; tr_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(32'h400 + 4*i, $urandom, 5'(i), $urandom, 6'b000001, 32'h0, 32'h0);
            step();
        end
        checkOutput("full_level", level, 16);
        checkOutput("full_ovf", ovf_cnt, 4);
        checkOutput("full_halt", halt_req, 1);
        checkOutput("full_head_seq", tr_rec.seq, 0);
        // Capture and pop together while full.
        tr_ready = 1'b1;
        applyStimulus(32'h500, $urandom, 5'd9, $urandom, 6'b000001, 32'h0, 32'h0);
        step();
        checkOutput("fullpop_level", level, 16);
        checkOutput("fullpop_ovf", ovf_cnt, 4);
        idle();
        for (int i = 0; i < 16; i++) step();
        checkOutput("drain_empty", tr_valid, 0);

        // Clear with a coincident capture.
        doReset();
        tr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h600 + 4*i, $urandom, 5'd2, $urandom, 6'b000001, 32'h0, 32'h0);
            step();
        end
        clear = 1'b1;
        applyStimulus(32'h700, $urandom, 5'd2, $urandom, 6'b000001, 32'h0, 32'h0);
        step();
        clear = 1'b0;
        checkOutput("clear_level", level, 0);
        checkOutput("clear_valid", tr_valid, 0);
        applyStimulus(32'h704, $urandom, 5'd2, $urandom, 6'b000001, 32'h0, 32'h0);
        step();
        checkOutput("clear_next_seq", tr_rec.seq, 6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            arst_n      = ($urandom_range(0, 499) != 0);
            clear       = ($urandom_range(0, 99) == 0);
            trace_en    = ($urandom_range(0, 9) != 0);
            filter_mask = 3'($urandom_range(0, 7));
            tr_ready    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0)
                applyStimulus($urandom, $urandom, 5'($urandom), $urandom, 6'($urandom), $urandom, $urandom);
            else
                idle();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
